// File: rtl/game_event_fifo.sv
// game_event_fifo: edge-detects game event lines and queues one entry per
// event for the Nios II, read through an Avalon-MM slave with pop-on-read.
// Optional build macro GAME_EVT_TIMESTAMP_EN adds a 12-bit frame counter
// (counted on VGA vsync falling edges) and stamps every entry with it.
// Without it, entries carry only the 3-bit event id and vs is unused.
module game_event_fifo #(
    parameter int DEPTH   = 16,
    parameter int NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic               vs,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef GAME_EVT_TIMESTAMP_EN
    localparam int EW = 15;
`else
    localparam int EW = 3;
`endif

    typedef enum logic [1:0] {
        ADDR_STATUS  = 2'd0,
        ADDR_DATA    = 2'd1,
        ADDR_CONTROL = 2'd2,
        ADDR_CLEAR   = 2'd3
    } reg_addr_e;

    reg_addr_e         addr;
    logic [7:0]        evt_pad, rising;
    logic [7:0]        evt_q, evt_d;
    logic [7:0]        pending_q, pending_d;
    logic [7:0]        enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              overflow_q, overflow_d;
    logic              irq_q, irq_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     push_entry, head_entry;
    logic [2:0]        push_id;
    logic              push_req, push, pop, flush, clr_ovf, wr_control;
    logic              full, empty;
    logic              unused_ok;
`ifdef GAME_EVT_TIMESTAMP_EN
    logic              vs_q, vs_d;
    logic [11:0]       frame_q, frame_d;
`endif

    assign addr       = reg_addr_e'(avs_address);
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign wr_control = avs_write && (addr == ADDR_CONTROL);
    assign flush      = avs_write && (addr == ADDR_CLEAR) && avs_writedata[0];
    assign clr_ovf    = avs_write && (addr == ADDR_CLEAR) && avs_writedata[1];
    assign pop        = avs_read && (addr == ADDR_DATA) && !empty;

`ifdef GAME_EVT_TIMESTAMP_EN
    assign push_entry = {frame_q, push_id};
    assign unused_ok  = ^avs_writedata[31:9];
`else
    assign push_entry = push_id;
    assign unused_ok  = ^{avs_writedata[31:9], vs};
`endif

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

    // Widen the event lines to the fixed 8-bit mask and pick the lowest pending id.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        evt_pad                = '0;
        evt_pad[NUM_EVT-1:0]   = evt_in;
        rising                 = evt_pad & ~evt_q;
        push_req               = |pending_q;
        push_id                = '0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) push_id = 3'(i);
        end
    end

    // Next-state logic: edge capture, push/pop arbitration, registers and read mux.
    always_comb begin
        evt_d      = evt_pad;
        pending_d  = pending_q | (rising & enable_q);
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rdata_d    = rdata_q;
        irq_d      = irq_en_q & ~empty;
        push       = 1'b0;

        if (wr_control) begin
            enable_d = avs_writedata[7:0];
            irq_en_d = avs_writedata[8];
        end

        // The selected pending bit is consumed whether it is stored or dropped.
        if (push_req) pending_d[push_id] = 1'b0;
        pending_d = pending_d & enable_d;

        if (clr_ovf) overflow_d = 1'b0;

        if (flush) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            push = push_req && (!full || pop);
            if (push_req && full && !pop) overflow_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        if (avs_read) begin
            rdata_d = '0;
            case (addr)
                ADDR_STATUS: begin
                    rdata_d[31]  = overflow_q;
                    rdata_d[30]  = full;
                    rdata_d[29]  = empty;
                    rdata_d[8]   = irq_en_q;
                    rdata_d[6:0] = 7'(count_q);
                end
                ADDR_DATA: begin
                    if (!empty) begin
                        rdata_d[31]  = 1'b1;
                        rdata_d[2:0] = head_entry[2:0];
`ifdef GAME_EVT_TIMESTAMP_EN
                        rdata_d[27:16] = head_entry[14:3];
`endif
                    end
                end
                ADDR_CONTROL: begin
                    rdata_d[7:0] = enable_q;
                    rdata_d[8]   = irq_en_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

`ifdef GAME_EVT_TIMESTAMP_EN
    // Frame counter advances once per vsync falling edge, wrapping naturally.
    always_comb begin
        vs_d    = vs;
        frame_d = frame_q;
        if (vs_q && !vs) frame_d = frame_q + 12'd1;
    end

    // Frame counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q    <= 1'b0;
            frame_q <= '0;
        end else begin
            vs_q    <= vs_d;
            frame_q <= frame_d;
        end
    end
`endif

    // Control and status state.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q      <= '0;
            pending_q  <= '0;
            enable_q   <= 8'hFF;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            evt_q      <= evt_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    // Entry storage.
    // NOTE: the array has no reset; only slots below count are ever read, so it maps to RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_game_event_fifo.sv
// Self-checking bench for game_event_fifo: drives event lines, vsync and the
// Avalon-MM slave, and checks popped entries against a scoreboard queue.
module tb_game_event_fifo;

    localparam int DEPTH   = 16;
    localparam int NUM_EVT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  evt_in;
    logic        vs;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          frame_m = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    game_event_fifo #(.DEPTH(DEPTH), .NUM_EVT(NUM_EVT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .evt_in        (evt_in),
        .vs            (vs),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        avs_address   = a;
        avs_writedata = wd;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    function automatic logic [31:0] data_word(input int frame, input int id);
        logic [11:0] f;
        logic [2:0]  i;
        i = 3'(id);
`ifdef GAME_EVT_TIMESTAMP_EN
        f = 12'(frame);
`else
        f = 12'd0;
`endif
        return {1'b1, 3'b0, f, 13'b0, i};
    endfunction

    function automatic logic [31:0] next_expected();
        if (exp_q.size() == 0) return 32'h0;
        return exp_q.pop_front();
    endfunction

    task automatic vs_pulse();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        frame_m++;
    endtask

    // One-cycle pulse on a line; the entry is in the FIFO when this returns.
    task automatic pulse(input int b);
        evt_in[b] = 1'b1;
        tick();
        evt_in[b] = 1'b0;
        tick();
        if (exp_q.size() < DEPTH) exp_q.push_back(data_word(frame_m, b));
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (irq !== 1'b0 || avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b readdata=%h, want 0 and 0", irq, avs_readdata);
        end
        reset_n = 1'b1;
        tick();
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL reset_status: got %h want %h", d, 32'h2000_0000);
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", d);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL reset_control: got %h want %h", d, 32'h0000_00FF);
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_single_event();
        logic [31:0] d, e;
        for (int i = 0; i < 3; i++) vs_pulse();
        pulse(1);
        e = next_expected();
        bus_read(2'd1, d);
        n_tests++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL single_data: got %h want %h", d, e);
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL single_empty_data: got %h want 0", d);
        end
    endtask

    task automatic test_multi_event();
        logic [31:0] d, e;
        evt_in = 8'h85;
        tick();
        evt_in = 8'h00;
        exp_q.push_back(data_word(frame_m, 0));
        exp_q.push_back(data_word(frame_m, 2));
        exp_q.push_back(data_word(frame_m, 7));
        // Back-to-back STATUS reads see one push per cycle.
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, d);
            e = (i == 0) ? 32'h2000_0000 : 32'(i);
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL multi_status_%0d: got %h want %h", i, d, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            e = next_expected();
            bus_read(2'd1, d);
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL multi_data_%0d: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        for (int i = 0; i < DEPTH + 1; i++) pulse(i % 8);
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'hC000_0010) begin
            n_fail++;
            $display("FAIL overflow_status: got %h want %h", d, 32'hC000_0010);
        end
        bus_write(2'd3, 32'h2);
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h4000_0010) begin
            n_fail++;
            $display("FAIL overflow_cleared: got %h want %h", d, 32'h4000_0010);
        end
        for (int i = 0; i < 2; i++) begin
            e = next_expected();
            bus_read(2'd1, d);
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL overflow_data_%0d: got %h want %h", i, d, e);
            end
        end
        bus_write(2'd3, 32'h1);
        exp_q.delete();
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL flush_status: got %h want %h", d, 32'h2000_0000);
        end
    endtask

    task automatic test_enable_irq();
        logic [31:0] d, e;
        bus_write(2'd2, 32'h100);
        evt_in = 8'hFF;
        tick();
        evt_in = 8'h00;
        tick();
        tick();
        tick();
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h2000_0100 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_events: status=%h irq=%b want %h and 0", d, irq, 32'h2000_0100);
        end
        bus_write(2'd2, 32'h1FF);
        evt_in[4] = 1'b1;
        tick();
        evt_in[4] = 1'b0;
        exp_q.push_back(data_word(frame_m, 4));
        tick();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_assert: got %b want 1", irq);
        end
        e = next_expected();
        bus_read(2'd1, d);
        n_tests++;
        if (d !== e || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_pop_data: data=%h irq=%b want %h and 1", d, irq, e);
        end
        tick();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_deassert: got %b want 0", irq);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d, e;
        for (int i = 0; i < DEPTH; i++) pulse(i % 8);
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h4000_0110) begin
            n_fail++;
            $display("FAIL full_status: got %h want %h", d, 32'h4000_0110);
        end
        // Edge now, so the push lands in the same cycle as the DATA read.
        evt_in[2] = 1'b1;
        tick();
        evt_in[2] = 1'b0;
        e = next_expected();
        bus_read(2'd1, d);
        exp_q.push_back(data_word(frame_m, 2));
        n_tests++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL full_pop_data: got %h want %h", d, e);
        end
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h4000_0110) begin
            n_fail++;
            $display("FAIL full_push_pop_status: got %h want %h", d, 32'h4000_0110);
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = next_expected();
            bus_read(2'd1, d);
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL drain_%0d: got %h want %h", i, d, e);
            end
        end
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h2000_0100) begin
            n_fail++;
            $display("FAIL drained_status: got %h want %h", d, 32'h2000_0100);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        pulse(3);
        tick();
        tick();
        avs_address = 2'd1;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (avs_readdata !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: readdata=%h irq=%b want 0 and 0", avs_readdata, irq);
        end
        avs_read = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        frame_m = 0;
        tick();
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h2000_0000) begin
            n_fail++;
            $display("FAIL midreset_status: got %h want %h", d, 32'h2000_0000);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL midreset_control: got %h want %h", d, 32'h0000_00FF);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        evt_in        = '0;
        vs            = 1'b1;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        test_reset();
        test_single_event();
        test_multi_event();
        test_overflow();
        test_enable_irq();
        test_full_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
